// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register: size codes, controller states
// and the access-size helper.
package mdr_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_FULL = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } mdr_state_e;

   // On a 32-bit datapath, SZ_FULL resolves to the same 4 bytes as a word.
   function automatic int access_bytes(input logic [1:0] sz, input int dw);
      case (sz)
         SZ_BYTE: access_bytes = 1;
         SZ_HALF: access_bytes = 2;
         SZ_WORD: access_bytes = 4;
         default: access_bytes = dw / 8;
      endcase
   endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Combinational lane logic: load extract/extend, store replication, byte enables
// and the alignment check.
module mdr_lane_align
   import mdr_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OFF_W      = 2
) (
   input  logic [1:0]              size,
   input  logic                    sign_ext,
   input  logic [OFF_W-1:0]        byte_off,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [DATA_WIDTH-1:0]   sdata,
   output logic [DATA_WIDTH-1:0]   load_val,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] be,
   output logic                    aligned
);

   localparam int BW  = DATA_WIDTH / 8;
   localparam int BW1 = BW + 1;

   int                    nbytes;
   logic [OFF_W-1:0]      off_mask;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;
   logic                  msb;
   logic [BW:0]           be_run;

   always_comb begin
      nbytes   = access_bytes(size, DATA_WIDTH);
      off_mask = OFF_W'(nbytes - 1);
      aligned  = (byte_off & off_mask) == '0;

      shifted  = rdata >> {byte_off, 3'b000};
      mask     = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - nbytes * 8);
      // mask ^ (mask >> 1) isolates the top bit of the selected lane
      msb      = |(shifted & (mask ^ (mask >> 1)));
      load_val = (shifted & mask) | ((sign_ext && msb) ? ~mask : '0);

      case (size)
         SZ_BYTE: wdata = {BW{sdata[7:0]}};
         SZ_HALF: wdata = {(BW/2){sdata[15:0]}};
         SZ_WORD: wdata = {(BW/4){sdata[31:0]}};
         default: wdata = sdata;
      endcase

      be_run = BW1'((1 << nbytes) - 1);
      be     = BW'(be_run << byte_off);
   end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with its memory-side request/acknowledge controller,
// wait-timeout and lane handling.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer; accepts mem_read > mem_write > MDRin
// RD_WAIT | load request out, waiting for mem_ack or timeout
// WR_WAIT | store request out, waiting for mem_ack or timeout
module mdr_mem_if
   import mdr_pkg::*;
#(
   parameter int                         DATA_WIDTH     = 32,
   parameter logic [DATA_WIDTH-1:0]      INIT           = '0,
   parameter int                         TIMEOUT_CYCLES = 16,
   parameter int                         OFF_W          = $clog2(DATA_WIDTH/8)
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic                    MDRin,
   input  logic [DATA_WIDTH-1:0]   BusMuxOut,
   input  logic [DATA_WIDTH-1:0]   Mdatain,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [1:0]              size,
   input  logic                    sign_ext,
   input  logic [OFF_W-1:0]        byte_off,
   input  logic                    mem_ack,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic                    busy,
   output logic                    done,
   output logic                    misalign_err,
   output logic                    timeout_err,
   output logic [DATA_WIDTH-1:0]   BusMuxIn
);

   localparam int BW = DATA_WIDTH / 8;

   mdr_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] q_q, q_d;
   logic [1:0]            size_q, size_d;
   logic                  sext_q, sext_d;
   logic [OFF_W-1:0]      off_q, off_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [BW-1:0]         be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  done_q, done_d;
   logic                  mis_q, mis_d;
   logic                  tmo_q, tmo_d;
   logic [7:0]            cnt_q, cnt_d;

   logic [1:0]            al_size;
   logic                  al_sext;
   logic [OFF_W-1:0]      al_off;
   logic [DATA_WIDTH-1:0] al_load;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic [BW-1:0]         al_be;
   logic                  al_aligned;

   // In IDLE the lane logic evaluates the incoming request; while waiting it
   // works from the latched access so the load path matches the request.
   assign al_size = (state_q == IDLE) ? size     : size_q;
   assign al_sext = (state_q == IDLE) ? sign_ext : sext_q;
   assign al_off  = (state_q == IDLE) ? byte_off : off_q;

   mdr_lane_align #(
      .DATA_WIDTH (DATA_WIDTH),
      .OFF_W      (OFF_W)
   ) u_lane (
      .size     (al_size),
      .sign_ext (al_sext),
      .byte_off (al_off),
      .rdata    (Mdatain),
      .sdata    (q_q),
      .load_val (al_load),
      .wdata    (al_wdata),
      .be       (al_be),
      .aligned  (al_aligned)
   );

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      size_d  = size_q;
      sext_d  = sext_q;
      off_d   = off_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               if (!al_aligned) begin
                  mis_d = 1'b1;
               end else begin
                  size_d  = size;
                  sext_d  = sign_ext;
                  off_d   = byte_off;
                  req_d   = 1'b1;
                  we_d    = !mem_read;
                  be_d    = al_be;
                  wdata_d = al_wdata;
                  tmo_d   = 1'b0;
                  cnt_d   = 8'(TIMEOUT_CYCLES - 1);
                  state_d = mem_read ? RD_WAIT : WR_WAIT;
               end
            end else if (MDRin) begin
               q_d = BusMuxOut;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (mem_ack) begin
               if (state_q == RD_WAIT) q_d = al_load;
               done_d  = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = '0;
               state_d = IDLE;
            end else if (cnt_q == 8'd0) begin
               tmo_d   = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            be_d    = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         q_q     <= INIT;
         size_q  <= SZ_BYTE;
         sext_q  <= 1'b0;
         off_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         off_q   <= off_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_req      = req_q;
   assign mem_we       = we_q;
   assign mem_be       = be_q;
   assign mem_wdata    = wdata_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign misalign_err = mis_q;
   assign timeout_err  = tmo_q;
   assign BusMuxIn     = q_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed bench for mdr_mem_if (32-bit, TIMEOUT_CYCLES=16).
module tb_mdr_mem_if;

   logic        clock = 1'b0;
   logic        clear;
   logic        MDRin;
   logic [31:0] BusMuxOut;
   logic [31:0] Mdatain;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [1:0]  byte_off;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        misalign_err;
   logic        timeout_err;
   logic [31:0] BusMuxIn;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   mdr_mem_if #(
      .DATA_WIDTH     (32),
      .INIT           (32'h0),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clock        (clock),
      .clear        (clear),
      .MDRin        (MDRin),
      .BusMuxOut    (BusMuxOut),
      .Mdatain      (Mdatain),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .size         (size),
      .sign_ext     (sign_ext),
      .byte_off     (byte_off),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .misalign_err (misalign_err),
      .timeout_err  (timeout_err),
      .BusMuxIn     (BusMuxIn)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic [1:0] off, input logic sx);
      mem_read  = rd;
      mem_write = wr;
      size      = sz;
      byte_off  = off;
      sign_ext  = sx;
      step();
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic ack(input logic [31:0] data);
      Mdatain = data;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
   endtask

   int  drop_at;
   bit  saw_done;

   initial begin
      clear = 1'b0; MDRin = 1'b0; BusMuxOut = '0; Mdatain = '0;
      mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
      byte_off = 2'b00; mem_ack = 1'b0;

      #12;
      chk("rst_q", BusMuxIn, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clock);
      clear = 1'b1;
      step();

      // bus path
      MDRin = 1'b1; BusMuxOut = 32'hDEADBEEF;
      step();
      MDRin = 1'b0;
      chk("mdrin_q", BusMuxIn, 32'hDEADBEEF);
      chk("mdrin_busy", 32'(busy), 32'd0);
      chk("mdrin_req", 32'(mem_req), 32'd0);

      // sign-extended byte load, three wait edges
      req(1'b1, 1'b0, 2'b00, 2'd2, 1'b1);
      chk("ldb_req", 32'(mem_req), 32'd1);
      chk("ldb_we", 32'(mem_we), 32'd0);
      chk("ldb_be", 32'(mem_be), 32'h4);
      chk("ldb_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) step();
      chk("ldb_wait_req", 32'(mem_req), 32'd1);
      chk("ldb_wait_done", 32'(done), 32'd0);
      ack(32'h0080_0000);
      chk("ldb_q", BusMuxIn, 32'hFFFFFF80);
      chk("ldb_done", 32'(done), 32'd1);
      chk("ldb_req_off", 32'(mem_req), 32'd0);
      chk("ldb_idle", 32'(busy), 32'd0);
      step();
      chk("ldb_done_pulse", 32'(done), 32'd0);

      // halfword store, immediate ack
      MDRin = 1'b1; BusMuxOut = 32'h0000_1234;
      step();
      MDRin = 1'b0;
      req(1'b0, 1'b1, 2'b01, 2'd2, 1'b0);
      chk("sth_we", 32'(mem_we), 32'd1);
      chk("sth_be", 32'(mem_be), 32'hC);
      chk("sth_wdata", mem_wdata, 32'h1234_1234);
      chk("sth_req", 32'(mem_req), 32'd1);
      ack(32'hFFFF_FFFF);
      chk("sth_done", 32'(done), 32'd1);
      chk("sth_q", BusMuxIn, 32'h0000_1234);
      chk("sth_req_off", 32'(mem_req), 32'd0);

      // misaligned word
      req(1'b1, 1'b0, 2'b10, 2'd1, 1'b0);
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_req", 32'(mem_req), 32'd0);
      chk("mis_busy", 32'(busy), 32'd0);
      step();
      chk("mis_pulse", 32'(misalign_err), 32'd0);
      chk("mis_req2", 32'(mem_req), 32'd0);
      chk("mis_q", BusMuxIn, 32'h0000_1234);

      // timeout
      req(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
      chk("tmo_req", 32'(mem_req), 32'd1);
      drop_at = 0; saw_done = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (done) saw_done = 1'b1;
         if (!mem_req && drop_at == 0) drop_at = i;
      end
      chk("tmo_drop_edge", 32'(drop_at), 32'd16);
      chk("tmo_err", 32'(timeout_err), 32'd1);
      chk("tmo_no_done", 32'(saw_done), 32'd0);
      chk("tmo_q", BusMuxIn, 32'h0000_1234);
      chk("tmo_idle", 32'(busy), 32'd0);
      req(1'b1, 1'b0, 2'b00, 2'd0, 1'b0);
      chk("tmo_clr", 32'(timeout_err), 32'd0);
      chk("tmo_new_req", 32'(mem_req), 32'd1);
      ack(32'h0000_00F0);
      chk("ldb_zext_q", BusMuxIn, 32'h0000_00F0);

      // read+write together, MDRin while busy
      req(1'b1, 1'b1, 2'b10, 2'd0, 1'b0);
      chk("rw_we", 32'(mem_we), 32'd0);
      chk("rw_req", 32'(mem_req), 32'd1);
      MDRin = 1'b1; BusMuxOut = 32'h0000_CAFE;
      step();
      MDRin = 1'b0;
      chk("busy_mdrin_q", BusMuxIn, 32'h0000_00F0);
      ack(32'h1122_3344);
      chk("rw_q", BusMuxIn, 32'h1122_3344);
      chk("rw_done", 32'(done), 32'd1);

      // sign-extended halfword at offset 0
      req(1'b1, 1'b0, 2'b01, 2'd0, 1'b1);
      chk("ldh_be", 32'(mem_be), 32'h3);
      ack(32'h5555_8001);
      chk("ldh_q", BusMuxIn, 32'hFFFF8001);

      // reset mid-transfer, then a late ack
      req(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
      chk("rst_mid_req", 32'(mem_req), 32'd1);
      #2 clear = 1'b0;
      #1;
      chk("rst_mid_q", BusMuxIn, 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_reqoff", 32'(mem_req), 32'd0);
      @(negedge clock);
      clear = 1'b1;
      ack(32'hABCD_EF01);
      chk("late_ack_done", 32'(done), 32'd0);
      chk("late_ack_q", BusMuxIn, 32'h0);
      chk("late_ack_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
